// File: rtl/phase_bus_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : phase_bus_scheduler
// Purpose  : Round-robin owner of the shared phase bus. Grants one command
//            engine at a time, waits for its completion, then enforces a
//            bus-idle guard interval before the next grant.
//            Optional hung-engine abort is built when PB_SCHED_TIMEOUT_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
module phase_bus_scheduler #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int GUARD_CYCLES    = 21,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] cmd_req,
  output logic [3:0] cmd_ack,
  output logic       cmd_err,
  output logic [3:0] sm_activate,
  input  logic [3:0] sm_complete,
  output logic       bus_busy,
  output logic [1:0] grant_id
);

  localparam int GUARD_EFF = (GUARD_CYCLES < 1) ? 1 : GUARD_CYCLES;
  localparam int GUARD_W   = $clog2(GUARD_EFF + 1);
  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_EFF);
  localparam logic [GUARD_W-1:0] GUARD_ONE  = GUARD_W'(1);

  if (CLOCK_FREQUENCY < 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("phase_bus_scheduler: CLOCK_FREQUENCY or TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_RELEASE = 2'd2,
    S_GUARD   = 2'd3
  } state_t;

  state_t               state_q,    state_d;
  logic [1:0]           rr_ptr_q,   rr_ptr_d;
  logic [1:0]           grant_id_q, grant_id_d;
  logic [3:0]           activate_q, activate_d;
  logic [3:0]           ack_q,      ack_d;
  logic                 busy_q,     busy_d;
  logic [GUARD_W-1:0]   guard_cnt_q, guard_cnt_d;

`ifdef PB_SCHED_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  logic [15:0]          to_cnt_q,    to_cnt_d;
  logic                 timed_out_q, timed_out_d;
  logic [1:0]           rel_cnt_q,   rel_cnt_d;
  logic                 err_q,       err_d;
`endif

  // Round-robin pick: lowest offset from rr_ptr_q wins, wrapping 3->0.
  logic       req_any;
  logic [1:0] winner;

  always_comb begin
    req_any = 1'b0;
    winner  = rr_ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (cmd_req[rr_ptr_q + 2'(i)]) begin
        req_any = 1'b1;
        winner  = rr_ptr_q + 2'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    activate_d  = activate_q;
    ack_d       = 4'b0000;
    guard_cnt_d = guard_cnt_q;
`ifdef PB_SCHED_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    timed_out_d = timed_out_q;
    rel_cnt_d   = rel_cnt_q;
    err_d       = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req_any) begin
          grant_id_d = winner;
          activate_d = 4'b0001 << winner;
          rr_ptr_d   = winner + 2'd1;
          state_d    = S_RUN;
`ifdef PB_SCHED_TIMEOUT_EN
          to_cnt_d    = 16'd0;
          timed_out_d = 1'b0;
`endif
        end
      end

      S_RUN: begin
        // Only the granted engine's completion flag is meaningful here.
        if (sm_complete[grant_id_q]) begin
          activate_d = 4'b0000;
          ack_d      = activate_q;
          state_d    = S_RELEASE;
`ifdef PB_SCHED_TIMEOUT_EN
          rel_cnt_d  = 2'd0;
        end else if ((to_cnt_q + 16'd1) >= TIMEOUT_LIM) begin
          activate_d  = 4'b0000;
          ack_d       = activate_q;
          err_d       = 1'b1;
          timed_out_d = 1'b1;
          rel_cnt_d   = 2'd0;
          state_d     = S_RELEASE;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
`endif
        end
      end

      S_RELEASE: begin
`ifdef PB_SCHED_TIMEOUT_EN
        // A timed-out engine may never drop its flag; give it three cycles.
        if (!sm_complete[grant_id_q] || (timed_out_q && rel_cnt_q == 2'd2)) begin
          guard_cnt_d = GUARD_LOAD;
          state_d     = S_GUARD;
        end else begin
          rel_cnt_d = rel_cnt_q + 2'd1;
        end
`else
        if (!sm_complete[grant_id_q]) begin
          guard_cnt_d = GUARD_LOAD;
          state_d     = S_GUARD;
        end
`endif
      end

      S_GUARD: begin
        if (guard_cnt_q <= GUARD_ONE) begin
          guard_cnt_d = '0;
          state_d     = S_IDLE;
        end else begin
          guard_cnt_d = guard_cnt_q - GUARD_ONE;
        end
      end

      default: begin
        activate_d = 4'b0000;
        state_d    = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= 2'd0;
      grant_id_q  <= 2'd0;
      activate_q  <= 4'b0000;
      ack_q       <= 4'b0000;
      busy_q      <= 1'b0;
      guard_cnt_q <= '0;
`ifdef PB_SCHED_TIMEOUT_EN
      to_cnt_q    <= 16'd0;
      timed_out_q <= 1'b0;
      rel_cnt_q   <= 2'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      activate_q  <= activate_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      guard_cnt_q <= guard_cnt_d;
`ifdef PB_SCHED_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      timed_out_q <= timed_out_d;
      rel_cnt_q   <= rel_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign sm_activate = activate_q;
  assign cmd_ack     = ack_q;
  assign bus_busy    = busy_q;
  assign grant_id    = grant_id_q;
`ifdef PB_SCHED_TIMEOUT_EN
  assign cmd_err     = err_q;
`else
  assign cmd_err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_phase_bus_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_bus_scheduler
// Purpose  : Scenario tasks plus a randomized run scored against an
//            event-level model of grant order and bus timing.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_phase_bus_scheduler;

  localparam int GUARD = 21;
  localparam int G_EFF = (GUARD < 1) ? 1 : GUARD;
  localparam int TMO   = 100;
  localparam int MAXC  = 16384;
  localparam int HANG  = 0;  // engine latency 0 means it never completes
  localparam int K     = 4;  // commands per engine in the random run

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] cmd_req = 4'b0000;
  logic [3:0] cmd_ack, sm_activate, sm_complete;
  logic       cmd_err, bus_busy;
  logic [1:0] grant_id;

  int total = 0;
  int bad   = 0;

  phase_bus_scheduler #(
    .CLOCK_FREQUENCY(27000000),
    .GUARD_CYCLES   (GUARD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cmd_req    (cmd_req),
    .cmd_ack    (cmd_ack),
    .cmd_err    (cmd_err),
    .sm_activate(sm_activate),
    .sm_complete(sm_complete),
    .bus_busy   (bus_busy),
    .grant_id   (grant_id)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         at;
    logic [3:0] vec;
    logic       err;
  } ev_t;

  int         cyc = 0;
  logic [3:0] req_hist [MAXC];
  logic       busy_hist[MAXC];
  ev_t        grants[$];
  ev_t        acks[$];
  int         lat[4]     = '{10, 10, 10, 10};
  int         act_cnt[4] = '{0, 0, 0, 0};
  logic [3:0] done_v   = 4'b0000;
  logic [3:0] spur     = 4'b0000;
  logic [3:0] act_prev = 4'b0000;

  assign sm_complete = done_v | spur;

  // Edge counter and the request vector the DUT samples at each edge.
  initial forever begin
    @(posedge clock);
    cyc++;
    if (cyc < MAXC) req_hist[cyc] = cmd_req;
  end

  // Engine models and event log; an engine raises complete `lat` cycles after
  // activate rises and clears it half a cycle after activate falls.
  initial forever begin
    @(negedge clock);
    if (cyc < MAXC) busy_hist[cyc] = bus_busy;
    if (sm_activate != 4'b0000 && act_prev == 4'b0000)
      grants.push_back(ev_t'{at: cyc, vec: sm_activate, err: 1'b0});
    if (cmd_ack != 4'b0000)
      acks.push_back(ev_t'{at: cyc, vec: cmd_ack, err: cmd_err});
    act_prev = sm_activate;
    for (int i = 0; i < 4; i++) begin
      if (sm_activate[i]) begin
        act_cnt[i]++;
        done_v[i] = (lat[i] != HANG) && (act_cnt[i] >= lat[i]);
      end else begin
        act_cnt[i] = 0;
        done_v[i]  = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    cmd_req = 4'b0000;
    spur    = 4'b0000;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    grants.delete();
    acks.delete();
  endtask

  // Raise `bits`, drop each request on its ack, return once the bus is idle.
  task automatic serve(input logic [3:0] bits, input int budget, output bit ok);
    ok = 1'b0;
    cmd_req = cmd_req | bits;
    for (int n = 0; n < budget; n++) begin
      @(negedge clock);
      cmd_req = cmd_req & ~cmd_ack;
      if (cmd_req == 4'b0000 && !bus_busy) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cmd_req = 4'b1111;
    repeat (3) @(negedge clock);
    total++;
    if ({sm_activate, cmd_ack, cmd_err, bus_busy, grant_id} !== 12'd0) begin
      bad++; $display("FAIL reset_hold: outputs=%h want 0", {sm_activate, cmd_ack, cmd_err, bus_busy, grant_id});
    end
    cmd_req = 4'b0000;
    reset_n = 1'b1;
    @(negedge clock);
    total++; if (sm_activate !== 4'b0000) begin bad++; $display("FAIL reset_activate: got %b want 0000", sm_activate); end
    total++; if (cmd_ack !== 4'b0000)     begin bad++; $display("FAIL reset_ack: got %b want 0000", cmd_ack); end
    total++; if (cmd_err !== 1'b0)        begin bad++; $display("FAIL reset_err: got %b want 0", cmd_err); end
    total++; if (bus_busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b want 0", bus_busy); end
    total++; if (grant_id !== 2'd0)       begin bad++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
  endtask

  task automatic test_single();
    bit ok;
    lat[1] = 40;
    do_reset();
    cmd_req = 4'b0010;
    @(negedge clock);
    total++; if (sm_activate !== 4'b0010) begin bad++; $display("FAIL single_activate: got %b want 0010", sm_activate); end
    total++; if (bus_busy !== 1'b1)       begin bad++; $display("FAIL single_busy: got %b want 1", bus_busy); end
    total++; if (grant_id !== 2'd1)       begin bad++; $display("FAIL single_grant_id: got %0d want 1", grant_id); end
    serve(4'b0010, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_finish: bus not idle within budget, got busy=%b want 0", bus_busy); end
    total++;
    if (acks.size() != 1 || grants.size() != 1) begin
      bad++; $display("FAIL single_ack_count: got acks=%0d grants=%0d want 1/1", acks.size(), grants.size());
    end else begin
      if (acks[0].vec !== 4'b0010 || acks[0].err !== 1'b0) begin
        bad++; $display("FAIL single_ack_vec: got %b err=%b want 0010 err=0", acks[0].vec, acks[0].err);
      end
      total++;
      if (acks[0].at - grants[0].at != 40) begin
        bad++; $display("FAIL single_run_len: got %0d want 40", acks[0].at - grants[0].at);
      end
      // bus_busy falls when the guard expires: RELEASE (1) + guard.
      total++;
      if (busy_hist[acks[0].at + G_EFF] !== 1'b1 || busy_hist[acks[0].at + G_EFF + 1] !== 1'b0) begin
        bad++; $display("FAIL single_busy_fall: got %b%b want 10 at ack+%0d/+%0d",
                        busy_hist[acks[0].at + G_EFF], busy_hist[acks[0].at + G_EFF + 1], G_EFF, G_EFF + 1);
      end
    end
  endtask

  task automatic test_all4();
    bit ok;
    lat = '{10, 10, 10, 10};
    do_reset();
    serve(4'b1111, 1000, ok);
    total++;
    if (!ok || grants.size() != 4 || acks.size() != 4) begin
      bad++; $display("FAIL all4_count: got ok=%0d grants=%0d acks=%0d want 1/4/4", ok, grants.size(), acks.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (grants[k].vec !== (4'b0001 << k) || acks[k].vec !== grants[k].vec || acks[k].at != grants[k].at + 10) begin
          bad++; $display("FAIL all4_grant%0d: got vec=%b ack=%b len=%0d want %b len=10",
                          k, grants[k].vec, acks[k].vec, acks[k].at - grants[k].at, 4'b0001 << k);
        end
        if (k > 0) begin
          total++;
          if (grants[k].at - acks[k-1].at != G_EFF + 2) begin
            bad++; $display("FAIL all4_gap%0d: got %0d want %0d", k, grants[k].at - acks[k-1].at, G_EFF + 2);
          end
        end
      end
    end
  endtask

  task automatic test_rr();
    bit ok;
    lat = '{5, 5, 5, 5};
    do_reset();
    serve(4'b0100, 300, ok);
    serve(4'b0101, 600, ok);
    total++;
    if (grants.size() != 3) begin
      bad++; $display("FAIL rr_count: got %0d grants want 3", grants.size());
    end else if (grants[0].vec !== 4'b0100 || grants[1].vec !== 4'b0001 || grants[2].vec !== 4'b0100) begin
      bad++; $display("FAIL rr_order: got %b,%b,%b want 0100,0001,0100", grants[0].vec, grants[1].vec, grants[2].vec);
    end
  endtask

  task automatic test_spurious();
    bit ok;
    lat[1] = 30;
    do_reset();
    spur = 4'b0100;
    serve(4'b0010, 400, ok);
    spur = 4'b0000;
    total++;
    if (!ok || acks.size() != 1 || grants.size() != 1) begin
      bad++; $display("FAIL spurious_count: got ok=%0d acks=%0d want 1/1", ok, acks.size());
    end else if (acks[0].vec !== 4'b0010 || acks[0].at - grants[0].at != 30) begin
      bad++; $display("FAIL spurious_ack: got %b after %0d want 0010 after 30", acks[0].vec, acks[0].at - grants[0].at);
    end
  endtask

  task automatic test_hang();
    bit ok;
    lat[3] = HANG;
    do_reset();
`ifdef PB_SCHED_TIMEOUT_EN
    serve(4'b1000, 600, ok);
    total++;
    if (!ok || acks.size() != 1 || grants.size() != 1) begin
      bad++; $display("FAIL timeout_count: got ok=%0d acks=%0d want 1/1", ok, acks.size());
    end else if (acks[0].vec !== 4'b1000 || acks[0].err !== 1'b1 || acks[0].at - grants[0].at != TMO) begin
      bad++; $display("FAIL timeout_ack: got %b err=%b after %0d want 1000 err=1 after %0d",
                      acks[0].vec, acks[0].err, acks[0].at - grants[0].at, TMO);
    end
`else
    cmd_req = 4'b1000;
    repeat (150) @(negedge clock);
    total++;
    if (sm_activate !== 4'b1000 || acks.size() != 0 || cmd_err !== 1'b0) begin
      bad++; $display("FAIL hang_hold: got act=%b acks=%0d err=%b want 1000/0/0", sm_activate, acks.size(), cmd_err);
    end
    lat[3] = 1;
    serve(4'b0000, 400, ok);
    total++;
    if (!ok || acks.size() != 1 || acks[0].err !== 1'b0) begin
      bad++; $display("FAIL hang_release: got ok=%0d acks=%0d want 1/1 with err=0", ok, acks.size());
    end
`endif
  endtask

  task automatic test_reset_midrun();
    bit ok;
    lat[3] = HANG;
    do_reset();
    cmd_req = 4'b1000;
    repeat (20) @(negedge clock);
    total++; if (sm_activate !== 4'b1000) begin bad++; $display("FAIL midrun_pre: got %b want 1000", sm_activate); end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({sm_activate, cmd_ack, cmd_err, bus_busy, grant_id} !== 12'd0) begin
      bad++; $display("FAIL midrun_async: outputs=%h want 0", {sm_activate, cmd_ack, cmd_err, bus_busy, grant_id});
    end
    cmd_req = 4'b0000;
    @(negedge clock);
    reset_n = 1'b1;
    // Leave rr_ptr at 2 with a hung bit-1 grant, then reset again.
    lat[1] = HANG;
    cmd_req = 4'b0010;
    repeat (5) @(negedge clock);
    #2 reset_n = 1'b0;
    cmd_req = 4'b0000;
    @(negedge clock);
    reset_n = 1'b1;
    lat[1] = 8;
    lat[3] = 8;
    cmd_req = 4'b1010;
    @(negedge clock);
    total++;
    if (sm_activate !== 4'b0010 || grant_id !== 2'd1) begin
      bad++; $display("FAIL midrun_rr_restart: got act=%b id=%0d want 0010 id=1", sm_activate, grant_id);
    end
    serve(4'b0000, 600, ok);
    total++; if (!ok) begin bad++; $display("FAIL midrun_drain: bus busy=%b want 0", bus_busy); end
  endtask

  task automatic test_random();
    bit         ok;
    int         e_next, ptr, id, g, exp_g;
    int         issued[4], served[4], wait_c[4];
    int         lat_tab[4][K];
    do_reset();
    e_next = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      issued[i] = 0; served[i] = 0; wait_c[i] = $urandom_range(0, 15);
    end
    ok = 1'b0;
    for (int n = 0; n < 6000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (cmd_req[i]) begin
          if (cmd_ack[i]) begin cmd_req[i] = 1'b0; wait_c[i] = $urandom_range(0, 30); end
        end else if (issued[i] < K) begin
          if (wait_c[i] == 0) begin
            lat[i] = $urandom_range(1, 20);
            lat_tab[i][issued[i]] = lat[i];
            issued[i]++;
            cmd_req[i] = 1'b1;
          end else begin
            wait_c[i]--;
          end
        end
      end
      if (issued[0] + issued[1] + issued[2] + issued[3] == 4 * K && cmd_req == 4'b0000 && !bus_busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
    total++;
    if (!ok || grants.size() != 4 * K || acks.size() != 4 * K) begin
      bad++; $display("FAIL rand_count: got ok=%0d grants=%0d acks=%0d want 1/%0d/%0d", ok, grants.size(), acks.size(), 4 * K, 4 * K);
    end
    ptr = 0;
    for (int k = 0; k < grants.size() && k < acks.size(); k++) begin
      g = grants[k].at;
      // Grant lands on the first edge, once the bus is free, that sees a request.
      exp_g = e_next;
      while (exp_g < g && req_hist[exp_g] == 4'b0000) exp_g++;
      total++;
      if (g != exp_g) begin bad++; $display("FAIL rand_grant_time%0d: got edge %0d want %0d", k, g, exp_g); end
      id = -1;
      for (int j = 0; j < 4; j++) if (id < 0 && req_hist[g][(ptr + j) % 4]) id = (ptr + j) % 4;
      total++;
      if (id < 0 || grants[k].vec !== (4'b0001 << id)) begin
        bad++; $display("FAIL rand_grant_id%0d: got %b want id %0d", k, grants[k].vec, id);
      end
      if (id >= 0 && served[id] < K) begin
        total++;
        if (acks[k].vec !== grants[k].vec || acks[k].err !== 1'b0 || acks[k].at != g + lat_tab[id][served[id]]) begin
          bad++; $display("FAIL rand_ack%0d: got %b len=%0d want %b len=%0d", k, acks[k].vec, acks[k].at - g,
                          grants[k].vec, lat_tab[id][served[id]]);
        end
        total++;
        if (busy_hist[g] !== 1'b1 || busy_hist[acks[k].at + G_EFF + 1] !== 1'b0) begin
          bad++; $display("FAIL rand_busy%0d: got %b%b want 10", k, busy_hist[g], busy_hist[acks[k].at + G_EFF + 1]);
        end
        served[id]++;
        ptr = (id + 1) % 4;
      end
      e_next = acks[k].at + G_EFF + 2;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all4();
    test_rr();
    test_spurious();
    test_hang();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
